forwarding_hazard_unit: RTL and testbench
=========================================

// Module: forwarding_hazard_unit
// PURPOSE
// - Next-generation forwarding + load-use hazard unit for the MIPS pipeline; sits beside ID/EX control.
// - Tracks in-flight destination registers internally in a 3-slot shadow pipeline (EX, MEM, WB).
// - Per cycle, drives operand-forward selectors for the ID-stage instruction, a load-use stall, and a stall counter.
// - Generalised over register-address width and load latency; handles flushes and the $zero register.
// PARAMETERS
// - REG_ADDR_W    5   register address width
// - LOAD_LATENCY  1   stall cycles per load-use hazard (1..3)
// - ZERO_REG_EN   1   1: register 0 is never forwarded and never causes a stall
// - CNT_W         16  width of the saturating stall_cycles counter
// PORTS
// - clk                input   1           system clock, rising edge
// - reset              input   1           synchronous, active-high
// - id_valid           input   1           ID stage holds a real instruction
// - rs_id              input   REG_ADDR_W  ID source register A
// - rt_id              input   REG_ADDR_W  ID source register B; also destination when reg_dst=0
// - rd_id              input   REG_ADDR_W  ID destination when reg_dst=1
// - reg_dst            input   1           1: dest=rd_id, 0: dest=rt_id
// - reg_write_id       input   1           ID instruction writes the register file
// - mem_read_id        input   1           ID instruction is a load
// - flush              input   1           squash the ID instruction (branch/jump taken)
// - selector_salida_a  output  2           forward select for rs: 00 regfile, 01 EX, 10 MEM, 11 WB
// - selector_salida_b  output  2           forward select for rt, same encoding
// - stall              output  1           hold PC and IF/ID; a bubble enters EX
// - stall_cycles       output  CNT_W       saturating count of cycles with stall=1
// BEHAVIOUR
// - Each slot holds {valid, dest, is_load}. Reset clears all slots, stall_cnt and stall_cycles.
// - After reset, selectors = 00, stall = 0, stall_cycles = 0.
// - Every edge: WB<=MEM, MEM<=EX. Stages after ID never stall.
// - EX update, by priority:
//   - flush=1: EX<=bubble.
//   - else stall=1: EX<=bubble.
//   - else: EX<={id_valid&reg_write_id, reg_dst?rd_id:rt_id, mem_read_id}.
// - Selectors are combinational from the slots and rs_id/rt_id.
//   - Match = slot valid and slot dest == source, excluding dest 0 when ZERO_REG_EN=1.
//   - Priority youngest first: EX(01) > MEM(10) > WB(11) > 00.
//   - Both operands are evaluated independently; both may select the same slot.
// - Load-use hazard (hz), combinational: id_valid & !flush & EX.valid & EX.is_load & (EX.dest matches rs_id or rt_id).
// - Stall counter stall_cnt, 2 bits:
//   - stall = hz | (stall_cnt != 0).
//   - On hz with stall_cnt == 0: stall_cnt <= LOAD_LATENCY-1.
//   - Else if stall_cnt != 0: decrement by 1.
//   - flush clears stall_cnt to 0 and forces stall = 0 in that cycle.
// - Net stall length per hazard is exactly LOAD_LATENCY cycles. The load then sits in MEM (latency 1), WB (2) or has retired (3).
// - Selectors are still driven while stall=1; the consumer ignores them.
// - stall_cycles increments on every cycle with stall=1 and holds at all-ones.
// - Reset mid-stall: the next cycle shows stall=0, all slots empty, selectors 00.
// - Back-to-back loads: each hazard is evaluated against the EX slot only. A new hazard can only start once stall_cnt == 0.
// TESTING
// - Reset, then idle: selectors 00, stall 0, stall_cycles 0 for 10 cycles.
// - add r3 (rd=3, reg_dst=1), then ID rs=3, rt=0: selector_salida_a=01, selector_salida_b=00. One cycle later with rs=3: a=10. Next cycle: a=11.
// - lw r5 (rt=5, reg_dst=0, mem_read=1), then ID rt_id=5, LOAD_LATENCY=1:
//   - stall=1 for exactly 1 cycle and stall_cycles=1.
//   - Next cycle selector_salida_b=10.
// - Same load-use case with LOAD_LATENCY=2: stall=1 for 2 cycles, then selector_salida_b=11.
// - Dest r0 written in EX, ID rs=0 and a load to r0: selectors 00, stall 0.
// - Load-use hazard with flush=1 in the same cycle: stall=0, EX bubble, stall_cycles unchanged. Reset asserted mid-stall: stall=0 on the next cycle.

Source files
------------

// File: rtl/forwarding_hazard_unit.sv
// Forwarding and load-use hazard unit for the MIPS pipeline.
// Shadows destinations of in-flight instructions in EX/MEM/WB slots, picks the youngest
// producer for each ID source operand, and stalls ID for LOAD_LATENCY cycles on a load-use.
module forwarding_hazard_unit #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned LOAD_LATENCY = 1,
    parameter int unsigned ZERO_REG_EN  = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] rs_id,
    input  logic [REG_ADDR_W-1:0] rt_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  reg_dst,
    input  logic                  reg_write_id,
    input  logic                  mem_read_id,
    input  logic                  flush,
    output logic [1:0]            selector_salida_a,
    output logic [1:0]            selector_salida_b,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_cycles
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  is_load;
    } slot_t;

    localparam slot_t      Bubble    = '0;
    // Counter holds the stall cycles still owed after the hazard cycle itself.
    localparam logic [1:0] CntReload = 2'(LOAD_LATENCY - 1);

    slot_t            ex_q, ex_d, mem_q, wb_q;
    logic [1:0]       stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             hz;
    logic             stall_int;

    function automatic logic slot_match(slot_t s, logic [REG_ADDR_W-1:0] src);
        logic zero_blocked;
        zero_blocked = (ZERO_REG_EN != 0) && (src == '0);
        return s.valid && (s.dest == src) && !zero_blocked;
    endfunction

    // Youngest producer wins: EX, then MEM, then WB, else the register file.
    function automatic logic [1:0] fwd_sel(slot_t ex, slot_t mem, slot_t wb,
                                           logic [REG_ADDR_W-1:0] src);
        if (slot_match(ex, src)) begin
            return 2'b01;
        end else if (slot_match(mem, src)) begin
            return 2'b10;
        end else if (slot_match(wb, src)) begin
            return 2'b11;
        end
        return 2'b00;
    endfunction

    // Operand forward selectors, driven every cycle including stalled ones.
    always_comb begin
        selector_salida_a = fwd_sel(ex_q, mem_q, wb_q, rs_id);
        selector_salida_b = fwd_sel(ex_q, mem_q, wb_q, rt_id);
    end

    // Load-use detection against the EX slot only; flush suppresses any stall.
    always_comb begin
        hz = id_valid && !flush && ex_q.valid && ex_q.is_load &&
             (slot_match(ex_q, rs_id) || slot_match(ex_q, rt_id));
        stall_int = !flush && (hz || (stall_cnt_q != 2'd0));
    end

    // Next state for the EX slot, stall counter and saturating stall statistic.
    always_comb begin
        ex_d           = Bubble;
        stall_cnt_d    = stall_cnt_q;
        stall_cycles_d = stall_cycles_q;

        if (!flush && !stall_int) begin
            ex_d.valid   = id_valid && reg_write_id;
            ex_d.dest    = reg_dst ? rd_id : rt_id;
            ex_d.is_load = mem_read_id;
        end

        if (flush) begin
            stall_cnt_d = 2'd0;
        end else if (hz && (stall_cnt_q == 2'd0)) begin
            stall_cnt_d = CntReload;
        end else if (stall_cnt_q != 2'd0) begin
            stall_cnt_d = stall_cnt_q - 2'd1;
        end

        if (stall_int && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    // Shadow pipeline and counters; later stages always advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q           <= Bubble;
            mem_q          <= Bubble;
            wb_q           <= Bubble;
            stall_cnt_q    <= 2'd0;
            stall_cycles_q <= '0;
        end else begin
            ex_q           <= ex_d;
            mem_q          <= ex_q;
            wb_q           <= mem_q;
            stall_cnt_q    <= stall_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall        = stall_int;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit: three instances (load latency 1, 2 and 3,
// the last with a 2-bit stall counter) share one ID-stage stimulus stream.
module tb_forwarding_hazard_unit;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic [4:0] rd_id;
    logic       reg_dst;
    logic       reg_write_id;
    logic       mem_read_id;
    logic       flush;

    logic [1:0]  a_l1, b_l1, a_l2, b_l2, a_l3, b_l3;
    logic        stall_l1, stall_l2, stall_l3;
    logic [15:0] cyc_l1, cyc_l2;
    logic [1:0]  cyc_l3;

    int n_checks;
    int n_pass;

    forwarding_hazard_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .ZERO_REG_EN(1), .CNT_W(16)) u_l1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .rs_id(rs_id), .rt_id(rt_id),
        .rd_id(rd_id), .reg_dst(reg_dst), .reg_write_id(reg_write_id),
        .mem_read_id(mem_read_id), .flush(flush), .selector_salida_a(a_l1),
        .selector_salida_b(b_l1), .stall(stall_l1), .stall_cycles(cyc_l1)
    );

    forwarding_hazard_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(2), .ZERO_REG_EN(1), .CNT_W(16)) u_l2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .rs_id(rs_id), .rt_id(rt_id),
        .rd_id(rd_id), .reg_dst(reg_dst), .reg_write_id(reg_write_id),
        .mem_read_id(mem_read_id), .flush(flush), .selector_salida_a(a_l2),
        .selector_salida_b(b_l2), .stall(stall_l2), .stall_cycles(cyc_l2)
    );

    forwarding_hazard_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(3), .ZERO_REG_EN(1), .CNT_W(2)) u_l3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .rs_id(rs_id), .rt_id(rt_id),
        .rd_id(rd_id), .reg_dst(reg_dst), .reg_write_id(reg_write_id),
        .mem_read_id(mem_read_id), .flush(flush), .selector_salida_a(a_l3),
        .selector_salida_b(b_l3), .stall(stall_l3), .stall_cycles(cyc_l3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic rdst, input logic rw,
                         input logic mr, input logic fl);
        id_valid     = v;
        rs_id        = rs;
        rt_id        = rt;
        rd_id        = rd;
        reg_dst      = rdst;
        reg_write_id = rw;
        mem_read_id  = mr;
        flush        = fl;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_eq("rst_sel_a", 32'(a_l1), 0);
            check_eq("rst_sel_b", 32'(b_l1), 0);
            check_eq("rst_stall", 32'(stall_l1), 0);
            check_eq("rst_cycles", 32'(cyc_l1), 0);
            next_cycle();
        end

        // add r3 then consumers of r3 walking through EX, MEM, WB.
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("add_sel_a_empty", 32'(a_l1), 0);
        next_cycle();
        drive(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("fwd_ex_a", 32'(a_l1), 1);
        check_eq("fwd_ex_b_r0", 32'(b_l1), 0);
        check_eq("fwd_ex_a_l2", 32'(a_l2), 1);
        next_cycle();
        drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("fwd_mem_a", 32'(a_l1), 2);
        check_eq("fwd_mem_b_same", 32'(b_l1), 2);
        next_cycle();
        drive(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("fwd_wb_a", 32'(a_l1), 3);
        check_eq("fwd_wb_b_r0", 32'(b_l1), 0);
        next_cycle();
        drive(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("fwd_retired_a", 32'(a_l1), 0);
        next_cycle();

        // Two writers of r4 back to back: the younger one must win.
        drive(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd4, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("prio_first_ex", 32'(a_l1), 1);
        next_cycle();
        drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("prio_ex_over_mem_a", 32'(a_l1), 1);
        check_eq("prio_ex_over_mem_b", 32'(b_l1), 1);
        next_cycle();
        drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("prio_mem_over_wb_a", 32'(a_l1), 2);
        check_eq("prio_mem_over_wb_b", 32'(b_l1), 2);
        next_cycle();
        idle(3);

        // lw r5, then a consumer of r5 held in ID.
        drive(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("lw_issue_stall", 32'(stall_l1), 0);
        next_cycle();
        drive(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("lu_c0_stall_l1", 32'(stall_l1), 1);
        check_eq("lu_c0_stall_l2", 32'(stall_l2), 1);
        check_eq("lu_c0_stall_l3", 32'(stall_l3), 1);
        check_eq("lu_c0_b_l1", 32'(b_l1), 1);
        check_eq("lu_c0_cycles_l1", 32'(cyc_l1), 0);
        next_cycle();
        check_eq("lu_c1_stall_l1", 32'(stall_l1), 0);
        check_eq("lu_c1_cycles_l1", 32'(cyc_l1), 1);
        check_eq("lu_c1_b_l1", 32'(b_l1), 2);
        check_eq("lu_c1_stall_l2", 32'(stall_l2), 1);
        check_eq("lu_c1_stall_l3", 32'(stall_l3), 1);
        next_cycle();
        check_eq("lu_c2_b_l1", 32'(b_l1), 3);
        check_eq("lu_c2_stall_l2", 32'(stall_l2), 0);
        check_eq("lu_c2_b_l2", 32'(b_l2), 3);
        check_eq("lu_c2_cycles_l2", 32'(cyc_l2), 2);
        check_eq("lu_c2_stall_l3", 32'(stall_l3), 1);
        check_eq("lu_c2_cycles_l3", 32'(cyc_l3), 2);
        next_cycle();
        check_eq("lu_c3_stall_l3", 32'(stall_l3), 0);
        check_eq("lu_c3_b_l3", 32'(b_l3), 0);
        check_eq("lu_c3_cycles_l3", 32'(cyc_l3), 3);
        check_eq("lu_c3_cycles_l1", 32'(cyc_l1), 1);
        check_eq("lu_c3_cycles_l2", 32'(cyc_l2), 2);
        next_cycle();
        idle(3);

        // $zero: a write and a load to r0 never forward nor stall.
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("zero_sel_a", 32'(a_l1), 0);
        check_eq("zero_sel_b", 32'(b_l1), 0);
        check_eq("zero_stall_a", 32'(stall_l1), 0);
        next_cycle();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("zero_load_stall_l1", 32'(stall_l1), 0);
        check_eq("zero_load_stall_l3", 32'(stall_l3), 0);
        check_eq("zero_load_sel_b", 32'(b_l1), 0);
        next_cycle();
        idle(3);

        // Load-use coinciding with a flush.
        drive(1'b1, 5'd0, 5'd6, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        next_cycle();
        drive(1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("flush_stall_l1", 32'(stall_l1), 0);
        check_eq("flush_stall_l2", 32'(stall_l2), 0);
        check_eq("flush_stall_l3", 32'(stall_l3), 0);
        check_eq("flush_sel_a", 32'(a_l1), 1);
        next_cycle();
        drive(1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("post_flush_stall", 32'(stall_l2), 0);
        check_eq("post_flush_sel_a", 32'(a_l1), 2);
        check_eq("post_flush_cycles_l1", 32'(cyc_l1), 1);
        check_eq("post_flush_cycles_l2", 32'(cyc_l2), 2);
        check_eq("post_flush_cycles_l3", 32'(cyc_l3), 3);
        next_cycle();
        idle(3);

        // Saturation on the 2-bit counter, then reset asserted mid-stall.
        drive(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        next_cycle();
        drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("sat_c0_stall_l3", 32'(stall_l3), 1);
        next_cycle();
        check_eq("sat_c1_stall_l1", 32'(stall_l1), 0);
        check_eq("sat_c1_cycles_l1", 32'(cyc_l1), 2);
        check_eq("sat_c1_stall_l2", 32'(stall_l2), 1);
        check_eq("sat_c1_cycles_l2", 32'(cyc_l2), 3);
        check_eq("sat_c1_stall_l3", 32'(stall_l3), 1);
        check_eq("sat_c1_cycles_l3", 32'(cyc_l3), 3);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        check_eq("rst_mid_stall_l2", 32'(stall_l2), 0);
        check_eq("rst_mid_stall_l3", 32'(stall_l3), 0);
        check_eq("rst_mid_sel_a_l1", 32'(a_l1), 0);
        check_eq("rst_mid_sel_a_l3", 32'(a_l3), 0);
        check_eq("rst_mid_cycles_l2", 32'(cyc_l2), 0);
        check_eq("rst_mid_cycles_l3", 32'(cyc_l3), 0);
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
